// File: rtl/fust_issue_scheduler.sv
// fust_issue_scheduler: per-FU IDLE/WAIT/READY/ISSUED tracking with tag wakeup,
// round-robin issue grant and speculative squash on branch mispredict.
module fust_issue_scheduler #(
    parameter int NUM_FU = 5,
    parameter int TAG_W  = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  alloc_en,
    input  logic [TAG_W-1:0]      alloc_fu,
    input  logic [TAG_W-1:0]      alloc_t1,
    input  logic [TAG_W-1:0]      alloc_t2,
    input  logic                  alloc_spec,
    output logic                  alloc_ack,
    input  logic                  wb_valid,
    input  logic [TAG_W-1:0]      wb_tag,
    input  logic                  issue_stall,
    output logic                  issue_valid,
    output logic [NUM_FU-1:0]     issue_fu,
    input  logic [NUM_FU-1:0]     fu_done,
    input  logic                  branch_miss,
    input  logic                  branch_resolved,
    output logic [NUM_FU*2-1:0]   fust_state
);
    typedef enum logic [1:0] {IDLE, WAIT, READY, ISSUED} state_t;

    state_t             st [NUM_FU];
    logic [TAG_W-1:0]   t1 [NUM_FU];
    logic [TAG_W-1:0]   t2 [NUM_FU];
    logic [TAG_W-1:0]   w1 [NUM_FU];
    logic [TAG_W-1:0]   w2 [NUM_FU];
    logic [NUM_FU-1:0]  spec;
    logic [TAG_W-1:0]   ptr, gnt_idx, a1, a2;
    logic               found, alloc_idle;

    // Writeback clears a matching nonzero tag; tag 0 never matches.
    function automatic logic [TAG_W-1:0] wake(input logic [TAG_W-1:0] t, input logic v,
                                              input logic [TAG_W-1:0] w);
        return (v && w != '0 && t == w) ? '0 : t;
    endfunction

    always_comb begin
        alloc_idle = 1'b0;
        found      = 1'b0;
        gnt_idx    = '0;
        a1         = wake(alloc_t1, wb_valid, wb_tag);
        a2         = wake(alloc_t2, wb_valid, wb_tag);
        for (int i = 0; i < NUM_FU; i++) begin
            if (alloc_fu == TAG_W'(i)) alloc_idle = (st[i] == IDLE);
            w1[i] = wake(t1[i], wb_valid, wb_tag);
            w2[i] = wake(t2[i], wb_valid, wb_tag);
            fust_state[2*i +: 2] = st[i];
        end
        // Search upward from the round-robin pointer with wrap.
        for (int k = 0; k < NUM_FU; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= NUM_FU) j = j - NUM_FU;
            if (!found && st[j] == READY) begin
                found   = 1'b1;
                gnt_idx = TAG_W'(j);
            end
        end
        issue_valid = found & ~RST & ~issue_stall & ~branch_miss;
        for (int i = 0; i < NUM_FU; i++) issue_fu[i] = issue_valid && gnt_idx == TAG_W'(i);
        alloc_ack = alloc_en & ~RST & ~branch_miss & (alloc_fu < TAG_W'(NUM_FU)) & alloc_idle;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_FU; i++) begin
                st[i] <= IDLE;
                t1[i] <= '0;
                t2[i] <= '0;
            end
            spec <= '0;
            ptr  <= '0;
        end else begin
            if (issue_valid) ptr <= (gnt_idx == TAG_W'(NUM_FU-1)) ? '0 : gnt_idx + 1'b1;
            for (int i = 0; i < NUM_FU; i++) begin
                if (branch_miss && spec[i] && (st[i] == WAIT || st[i] == READY)) begin
                    st[i]   <= IDLE;
                    t1[i]   <= '0;
                    t2[i]   <= '0;
                    spec[i] <= 1'b0;
                end else begin
                    if (branch_resolved && !branch_miss) spec[i] <= 1'b0;
                    case (st[i])
                        IDLE: if (alloc_ack && alloc_fu == TAG_W'(i)) begin
                            t1[i]   <= a1;
                            t2[i]   <= a2;
                            spec[i] <= alloc_spec & ~branch_resolved;
                            st[i]   <= (a1 == '0 && a2 == '0) ? READY : WAIT;
                        end
                        WAIT: begin
                            t1[i] <= w1[i];
                            t2[i] <= w2[i];
                            if (w1[i] == '0 && w2[i] == '0) st[i] <= READY;
                        end
                        READY: if (issue_valid && gnt_idx == TAG_W'(i)) st[i] <= ISSUED;
                        ISSUED: if (fu_done[i]) begin
                            st[i]   <= IDLE;
                            t1[i]   <= '0;
                            t2[i]   <= '0;
                            spec[i] <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_fust_issue_scheduler.sv
// tb_fust_issue_scheduler: directed vectors with hand-computed expectations
// for allocation, wakeup, round-robin issue, squash and reset.
module tb_fust_issue_scheduler;
    logic       CLK, RST, alloc_en, alloc_spec, alloc_ack, wb_valid, issue_stall;
    logic       issue_valid, branch_miss, branch_resolved;
    logic [2:0] alloc_fu, alloc_t1, alloc_t2, wb_tag;
    logic [4:0] issue_fu, fu_done;
    logic [9:0] fust_state;
    int         n_chk = 0, n_pass = 0;

    fust_issue_scheduler dut (
        .CLK(CLK), .RST(RST), .alloc_en(alloc_en), .alloc_fu(alloc_fu),
        .alloc_t1(alloc_t1), .alloc_t2(alloc_t2), .alloc_spec(alloc_spec),
        .alloc_ack(alloc_ack), .wb_valid(wb_valid), .wb_tag(wb_tag),
        .issue_stall(issue_stall), .issue_valid(issue_valid), .issue_fu(issue_fu),
        .fu_done(fu_done), .branch_miss(branch_miss), .branch_resolved(branch_resolved),
        .fust_state(fust_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [1:0] stf(input int i);
        return fust_state[2*i +: 2];
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RST = 0; alloc_en = 0; alloc_fu = 0; alloc_t1 = 0; alloc_t2 = 0; alloc_spec = 0;
        wb_valid = 0; wb_tag = 0; issue_stall = 0; fu_done = 0;
        branch_miss = 0; branch_resolved = 0;
    endtask

    task automatic alloc(input logic [2:0] fu, input logic [2:0] a, input logic [2:0] b,
                         input logic s);
        alloc_en = 1; alloc_fu = fu; alloc_t1 = a; alloc_t2 = b; alloc_spec = s;
    endtask

    initial begin
        idle();
        RST = 1; alloc_en = 1;
        #1 check("ack_in_rst", alloc_ack, 0);
        step(); step();
        idle();
        #1 check("rst_state", fust_state, 0);
        check("rst_iv", issue_valid, 0);
        check("rst_ack", alloc_ack, 0);

        // basic flow on FU2
        alloc(2, 0, 0, 0);
        #1 check("t1_ack", alloc_ack, 1);
        step(); idle();
        #1 check("t1_ready", stf(2), 2);
        check("t1_iv", issue_valid, 1);
        check("t1_fu", issue_fu, 5'b00100);
        step();
        check("t1_issued", stf(2), 3);
        check("t1_iv_off", issue_valid, 0);
        fu_done = 5'b00100;
        step(); idle();
        check("t1_idle", stf(2), 0);

        // wakeup via writeback on FU1, pointer now 3
        alloc(1, 3, 0, 0);
        #1 check("t2_ack", alloc_ack, 1);
        step(); idle();
        #1 check("t2_wait", stf(1), 1);
        check("t2_iv", issue_valid, 0);
        step();
        wb_valid = 1; wb_tag = 3;
        #1 check("t2_still_wait", stf(1), 1);
        step(); idle();
        #1 check("t2_ready", stf(1), 2);
        check("t2_fu", issue_fu, 5'b00010);
        step();
        check("t2_issued", stf(1), 3);
        fu_done = 5'b00010;
        step(); idle();
        check("t2_idle", stf(1), 0);

        // writeback bypass at allocation on FU0, pointer now 2
        alloc(0, 4, 0, 0); wb_valid = 1; wb_tag = 4;
        #1 check("byp_ack", alloc_ack, 1);
        step(); idle();
        #1 check("byp_ready", stf(0), 2);
        check("byp_fu", issue_fu, 5'b00001);
        step();
        fu_done = 5'b00001;
        step(); idle();
        check("byp_idle", stf(0), 0);

        // busy and out-of-range allocations, pointer now 1
        alloc(3, 0, 0, 0);
        step(); idle();
        #1 check("t5_fu", issue_fu, 5'b01000);
        step();
        check("t5_issued", stf(3), 3);
        alloc(3, 0, 0, 0);
        #1 check("t5_busy_ack", alloc_ack, 0);
        alloc_fu = 6;
        #1 check("t5_range_ack", alloc_ack, 0);
        step(); idle();
        #1 check("t5_unchanged", stf(3), 3);
        fu_done = 5'b01000;
        step(); idle();

        // branch mispredict squash, pointer now 4
        alloc(4, 0, 0, 1);
        step(); idle();
        #1 check("t4_fu4", issue_fu, 5'b10000);
        step();
        issue_stall = 1;
        alloc(2, 0, 0, 1);
        step();
        alloc(0, 2, 0, 0);
        step();
        alloc(1, 0, 0, 0); issue_stall = 0; branch_miss = 1;
        #1 check("t4_iv", issue_valid, 0);
        check("t4_ack", alloc_ack, 0);
        step(); idle();
        #1 check("t4_fu2", stf(2), 0);
        check("t4_fu4st", stf(4), 3);
        check("t4_fu0", stf(0), 1);
        check("t4_fu1", stf(1), 0);
        check("t4_iv_after", issue_valid, 0);

        // mid-operation reset, pointer now 0
        alloc(1, 0, 0, 0);
        step();
        alloc(2, 1, 0, 0);
        #1 check("t6_fu", issue_fu, 5'b00010);
        step(); idle();
        #1 check("t6_fu1", stf(1), 3);
        check("t6_fu2", stf(2), 1);
        RST = 1;
        #1 check("t6_iv", issue_valid, 0);
        step(); idle();
        #1 check("t6_state", fust_state, 0);

        // round-robin order with a stall window
        issue_stall = 1;
        alloc(0, 0, 0, 0);
        step();
        alloc(1, 0, 0, 0);
        step();
        alloc(3, 0, 0, 0);
        step();
        alloc_en = 0;
        #1 check("rr_state", fust_state, 10'h08A);
        check("rr_stall_iv", issue_valid, 0);
        issue_stall = 0;
        #1 check("rr_g0", issue_fu, 5'b00001);
        step();
        issue_stall = 1;
        #1 check("rr_stall1", issue_valid, 0);
        step();
        #1 check("rr_stall2", issue_valid, 0);
        step();
        issue_stall = 0;
        #1 check("rr_g1", issue_fu, 5'b00010);
        step();
        #1 check("rr_g3", issue_fu, 5'b01000);
        step();
        #1 check("rr_done_iv", issue_valid, 0);
        check("rr_final", fust_state, 10'h0CF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
